// File: rtl/a7seg_pkg.sv
// Shared constants for the 7-segment scan controller: register map and
// control/status bit positions.
package a7seg_pkg;

   localparam logic A7_ADDR_DATA = 1'b0;
   localparam logic A7_ADDR_CTRL = 1'b1;

   localparam int CTRL_BLINK = 0;
   localparam int CTRL_IMM   = 1;
   localparam int STAT_PEND  = 2;

endpackage

// File: rtl/a7seg_scan_ctrl_if.sv
// CPU-side register access bus of the scan controller.
interface a7seg_scan_ctrl_if;

   logic        wr_en;
   logic        wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rd_addr;
   logic [31:0] rd_data;

   modport master (
      output wr_en, wr_addr, wr_be, wr_data, rd_addr,
      input  rd_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_be, wr_data, rd_addr,
      output rd_data
   );

endinterface

// File: rtl/a7seg_prescaler.sv
// Modulo-N counter advancing on en; tick marks the enabled cycle that wraps.
module a7seg_prescaler #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/a7seg_scan_ctrl.sv
// Digit scan, blink and frame-synchronous data commit for the 4-digit
// 7-segment mux stage, with a shadow/control register pair on the CPU bus.
module a7seg_scan_ctrl
   import a7seg_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int FLASH_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   a7seg_scan_ctrl_if.slave        bus,
   output logic [1:0]              scan,
   output logic                    flash,
   output logic [31:0]             data,
   output logic                    frame_tick
);

   logic        slot_tick;
   logic        frame_end;
   logic        flash_tick;
   logic        shadow_wr;
   logic        ctrl_wr;
   logic [31:0] shadow;
   logic [31:0] merged;
   logic        blink_en;
   logic        imm;
   logic        pending;
   logic        phase;
   logic        blink_nxt;
   logic        imm_nxt;
   logic        phase_nxt;
   logic        pending_nxt;
   logic [31:0] data_nxt;
   logic [31:0] rd_nxt;

   a7seg_prescaler #(.N(SCAN_DIV)) u_slot_div (
      .clk  (clk),
      .rst  (rst),
      .en   (1'b1),
      .tick (slot_tick)
   );

   assign frame_end = slot_tick && (scan == 2'd3);

   a7seg_prescaler #(.N(FLASH_FRAMES)) u_flash_div (
      .clk  (clk),
      .rst  (rst),
      .en   (frame_end),
      .tick (flash_tick)
   );

   assign shadow_wr = bus.wr_en && (bus.wr_addr == A7_ADDR_DATA) && (|bus.wr_be);
   assign ctrl_wr   = bus.wr_en && (bus.wr_addr == A7_ADDR_CTRL) && bus.wr_be[0];

   always_comb begin
      merged = shadow;
      for (int i = 0; i < 4; i++) begin
         if (bus.wr_be[i]) merged[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
   end

   // flash follows the new blink_en/phase on the same edge they change
   assign blink_nxt = ctrl_wr ? bus.wr_data[CTRL_BLINK] : blink_en;
   assign imm_nxt   = ctrl_wr ? bus.wr_data[CTRL_IMM]   : imm;
   assign phase_nxt = phase ^ flash_tick;

   // A write landing together with a commit is either merged into it or
   // re-arms pending, so no write is dropped.
   always_comb begin
      data_nxt    = data;
      pending_nxt = pending;
      if (imm && pending) begin
         data_nxt    = shadow;
         pending_nxt = shadow_wr;
      end else if (!imm && frame_end && (pending || shadow_wr)) begin
         data_nxt    = merged;
         pending_nxt = 1'b0;
      end else if (shadow_wr) begin
         pending_nxt = 1'b1;
      end
   end

   always_comb begin
      rd_nxt = '0;
      if (bus.rd_addr == A7_ADDR_CTRL) begin
         rd_nxt[CTRL_BLINK] = blink_en;
         rd_nxt[CTRL_IMM]   = imm;
         rd_nxt[STAT_PEND]  = pending;
      end else begin
         rd_nxt = shadow;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan        <= '0;
         frame_tick  <= 1'b0;
         shadow      <= '0;
         blink_en    <= 1'b0;
         imm         <= 1'b0;
         pending     <= 1'b0;
         phase       <= 1'b0;
         flash       <= 1'b0;
         data        <= '0;
         bus.rd_data <= '0;
      end else begin
         if (slot_tick) scan <= scan + 2'd1;
         frame_tick  <= frame_end;
         if (shadow_wr) shadow <= merged;
         blink_en    <= blink_nxt;
         imm         <= imm_nxt;
         pending     <= pending_nxt;
         phase       <= phase_nxt;
         flash       <= blink_nxt & phase_nxt;
         data        <= data_nxt;
         bus.rd_data <= rd_nxt;
      end
   end

endmodule

// File: tb/tb_a7seg_scan_ctrl.sv
// Directed bench for a7seg_scan_ctrl with SCAN_DIV=4, FLASH_FRAMES=2.
module tb_a7seg_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  scan;
   logic        flash;
   logic [31:0] data;
   logic        frame_tick;

   int n_checks;
   int n_fail;
   int cyc;

   a7seg_scan_ctrl_if bus_if ();

   a7seg_scan_ctrl #(.SCAN_DIV(4), .FLASH_FRAMES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if),
      .scan       (scan),
      .flash      (flash),
      .data       (data),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wr(input logic addr, input logic [3:0] be, input logic [31:0] d);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = addr;
      bus_if.wr_be   = be;
      bus_if.wr_data = d;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      bus_if.wr_en   = 1'b0;
      bus_if.wr_addr = 1'b0;
      bus_if.wr_be   = 4'h0;
      bus_if.wr_data = '0;
      bus_if.rd_addr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_scan", 32'(scan), 32'd0);
      check("rst_flash", 32'(flash), 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_rd_data", bus_if.rd_data, 32'd0);
      check("rst_frame_tick", 32'(frame_tick), 32'd0);
      rst = 1'b0;

      // idle scanning
      for (int k = 1; k <= 40; k++) begin
         tick();
         check("idle_scan", 32'(scan), 32'((k / 4) % 4));
         check("idle_frame_tick", 32'(frame_tick), (k % 16 == 0) ? 32'd1 : 32'd0);
         check("idle_flash", 32'(flash), 32'd0);
         check("idle_data", data, 32'd0);
      end

      // mid-frame write held until frame boundary
      wr(1'b0, 4'hF, 32'h1234_5678);
      tick();
      bus_if.wr_en   = 1'b0;
      bus_if.rd_addr = 1'b1;
      tick();
      check("pend_status", bus_if.rd_data, 32'd4);
      check("pend_data_held", data, 32'd0);
      bus_if.rd_addr = 1'b0;
      tick();
      check("rd_shadow", bus_if.rd_data, 32'h1234_5678);
      goto(47);
      check("pre_commit_scan", 32'(scan), 32'd3);
      check("pre_commit_data", data, 32'd0);
      tick();
      check("commit_scan", 32'(scan), 32'd0);
      check("commit_frame_tick", 32'(frame_tick), 32'd1);
      check("commit_data", data, 32'h1234_5678);

      // partial write coinciding with frame_end, read-during-write
      goto(63);
      wr(1'b0, 4'b0101, 32'hAABB_CCDD);
      bus_if.rd_addr = 1'b0;
      tick();
      bus_if.wr_en = 1'b0;
      check("merge_data", data, 32'h12BB_56DD);
      check("merge_frame_tick", 32'(frame_tick), 32'd1);
      check("rdw_old_shadow", bus_if.rd_data, 32'h1234_5678);
      bus_if.rd_addr = 1'b1;
      tick();
      check("merge_pending_clear", bus_if.rd_data, 32'd0);

      // immediate mode with blink
      wr(1'b1, 4'h1, 32'h0000_0003);
      tick();
      wr(1'b0, 4'hF, 32'hCAFE_F00D);
      tick();
      bus_if.wr_en = 1'b0;
      check("ctrl_read", bus_if.rd_data, 32'd3);
      check("imm_data_before", data, 32'h12BB_56DD);
      tick();
      check("imm_data_after", data, 32'hCAFE_F00D);
      check("imm_status_pending", bus_if.rd_data, 32'd7);
      tick();
      check("imm_pending_clear", bus_if.rd_data, 32'd3);

      goto(95);
      check("flash_lo_95", 32'(flash), 32'd0);
      tick();
      check("flash_hi_96", 32'(flash), 32'd1);
      goto(127);
      check("flash_hi_127", 32'(flash), 32'd1);
      tick();
      check("flash_lo_128", 32'(flash), 32'd0);
      goto(160);
      check("flash_hi_160", 32'(flash), 32'd1);
      goto(165);
      wr(1'b1, 4'h1, 32'h0000_0002);
      tick();
      bus_if.wr_en = 1'b0;
      check("blink_off", 32'(flash), 32'd0);
      goto(170);
      wr(1'b1, 4'h1, 32'h0000_0003);
      tick();
      bus_if.wr_en = 1'b0;
      check("blink_on_phase_kept", 32'(flash), 32'd1);
      goto(192);
      check("flash_lo_192", 32'(flash), 32'd0);

      // reset mid-frame with a pending write
      tick();
      wr(1'b1, 4'h1, 32'h0000_0000);
      tick();
      wr(1'b0, 4'hF, 32'h0000_0055);
      tick();
      bus_if.wr_en   = 1'b0;
      bus_if.rd_addr = 1'b0;
      tick();
      check("pre_rst_shadow", bus_if.rd_data, 32'h0000_0055);
      bus_if.rd_addr = 1'b1;
      tick();
      check("pre_rst_pending", bus_if.rd_data, 32'd4);
      goto(201);
      check("pre_rst_scan", 32'(scan), 32'd2);
      check("pre_rst_data", data, 32'hCAFE_F00D);
      rst = 1'b1;
      #1;
      check("async_rst_scan", 32'(scan), 32'd0);
      check("async_rst_flash", 32'(flash), 32'd0);
      check("async_rst_data", data, 32'd0);
      check("async_rst_rd_data", bus_if.rd_data, 32'd0);
      check("async_rst_frame_tick", 32'(frame_tick), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      tick();
      check("post_rst_pending", bus_if.rd_data, 32'd0);
      check("post_rst_scan1", 32'(scan), 32'd0);
      goto(3);
      check("post_rst_scan3", 32'(scan), 32'd0);
      tick();
      check("post_rst_scan4", 32'(scan), 32'd1);

      // zero byte-enable write changes nothing
      wr(1'b0, 4'h0, 32'hFFFF_FFFF);
      tick();
      bus_if.wr_en   = 1'b0;
      bus_if.rd_addr = 1'b1;
      tick();
      check("be0_no_pending", bus_if.rd_data, 32'd0);
      bus_if.rd_addr = 1'b0;
      tick();
      check("be0_shadow", bus_if.rd_data, 32'd0);
      check("be0_data", data, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
